// File: rtl/echo_cancel_pkg.sv
// Shared definitions for the echo canceller and its double-precision FPU:
// op codes, controller states, rounding modes and the unpacked operand record.
package echo_cancel_pkg;

   localparam logic [2:0] FPU_ADD = 3'b000;
   localparam logic [2:0] FPU_SUB = 3'b001;
   localparam logic [2:0] FPU_MUL = 3'b010;
   localparam logic [2:0] FPU_DIV = 3'b011;

   localparam logic [1:0] RM_NEAREST = 2'b00;
   localparam logic [1:0] RM_ZERO    = 2'b01;
   localparam logic [1:0] RM_UP      = 2'b10;
   localparam logic [1:0] RM_DOWN    = 2'b11;

   // Smallest positive normal double; the estimator comes out of reset with it.
   localparam logic [63:0] COEF_RESET = 64'h0010000000000000;
   localparam logic [63:0] QNAN       = 64'h7FF8000000000000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } state_t;

   // Operand with a normalised 53-bit significand; exp is a two's-complement
   // biased exponent so subnormal inputs can sit below 1.
   typedef struct packed {
      logic        sign;
      logic [12:0] exp;
      logic [52:0] man;
      logic        zero;
      logic        inf;
      logic        nan;
   } fp_t;

endpackage

// File: rtl/echo_cancel_fpu.sv
// Double-precision add/sub/mul unit with a one-cycle enable/ready handshake.
// Division is not built into this variant; the DIV code returns a quiet NaN.
module echo_cancel_fpu
   import echo_cancel_pkg::*;
(
   input  logic        clk_operation,
   input  logic        rst,
   input  logic        enable,
   input  logic [1:0]  rmode,
   input  logic [2:0]  op,
   input  logic [63:0] opa,
   input  logic [63:0] opb,
   output logic [63:0] out,
   output logic        ready
);

   // NOTE: functions are automatic and use blocking assignments on locals only.
   function automatic logic [6:0] lzc57(input logic [56:0] x);
      logic [6:0] n;
      logic       found;
      n     = 7'd57;
      found = 1'b0;
      for (int i = 56; i >= 0; i--) begin
         if (!found && x[i]) begin
            n     = 7'(56 - i);
            found = 1'b1;
         end
      end
      return n;
   endfunction

   function automatic logic [56:0] shr_sticky(input logic [56:0] x, input logic [12:0] amt);
      logic [56:0] mask;
      if (amt >= 13'd57) return {56'd0, |x};
      mask = ~({57{1'b1}} << amt);
      return (x >> amt) | {56'd0, |(x & mask)};
   endfunction

   function automatic fp_t unpack(input logic [63:0] x);
      fp_t        f;
      logic [6:0] lz;
      f.sign = x[63];
      f.nan  = (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
      f.inf  = (x[62:52] == 11'h7FF) && (x[51:0] == 52'd0);
      f.zero = (x[62:0] == 63'd0);
      f.exp  = {2'b00, x[62:52]};
      f.man  = {1'b1, x[51:0]};
      if (x[62:52] == 11'd0) begin
         lz    = lzc57({1'b0, x[51:0], 4'd0});
         f.man = {1'b0, x[51:0]} << lz;
         f.exp = 13'd1 - {6'd0, lz};
      end
      return f;
   endfunction

   // sig carries the unit bit at [55], guard/round/sticky in [2:0], carry in [56].
   function automatic logic [63:0] round_pack(input logic sign, input logic signed [12:0] e,
                                              input logic [56:0] sig, input logic [1:0] rm);
      logic [56:0]        s;
      logic signed [12:0] ex;
      logic signed [12:0] enc;
      logic [6:0]         lz;
      logic [53:0]        m;
      logic               inc;
      logic               lost;
      s  = sig;
      ex = e;
      if (s == 57'd0) return {sign, 63'd0};
      if (s[56]) begin
         s  = shr_sticky(s, 13'd1);
         ex = ex + 13'sd1;
      end else begin
         lz = lzc57(s) - 7'd1;
         s  = s << lz;
         ex = ex - $signed({6'd0, lz});
      end
      if (ex < 13'sd1) begin
         s   = shr_sticky(s, 13'(13'sd1 - ex));
         enc = 13'sd0;
      end else begin
         enc = ex;
      end
      lost = |s[2:0];
      case (rm)
         RM_NEAREST: inc = s[2] & (s[1] | s[0] | s[3]);
         RM_UP:      inc = ~sign & lost;
         RM_DOWN:    inc = sign & lost;
         default:    inc = 1'b0;
      endcase
      m = {1'b0, s[55:3]} + 54'(inc);
      if (m[53]) begin
         m   = m >> 1;
         enc = enc + 13'sd1;
      end else if (enc == 13'sd0 && m[52]) begin
         enc = 13'sd1;
      end
      if (enc >= 13'sd2047) begin
         if (rm == RM_ZERO || (rm == RM_UP && sign) || (rm == RM_DOWN && !sign))
            return {sign, 11'h7FE, {52{1'b1}}};
         return {sign, 11'h7FF, 52'd0};
      end
      return {sign, enc[10:0], m[51:0]};
   endfunction

   function automatic logic [63:0] add_sub(input logic [63:0] a, input logic [63:0] b,
                                           input logic subtract, input logic [1:0] rm);
      fp_t         x;
      fp_t         y;
      fp_t         t;
      logic [56:0] sx;
      logic [56:0] sy;
      logic [12:0] d;
      x = unpack(a);
      y = unpack(b);
      y.sign = y.sign ^ subtract;
      if (x.nan || y.nan) return QNAN;
      if (x.inf && y.inf && (x.sign != y.sign)) return QNAN;
      if (x.inf) return {x.sign, 11'h7FF, 52'd0};
      if (y.inf) return {y.sign, 11'h7FF, 52'd0};
      if (x.zero && y.zero) return {(x.sign == y.sign) ? x.sign : (rm == RM_DOWN), 63'd0};
      if (x.zero) return {y.sign, b[62:0]};
      if (y.zero) return a;
      if ($signed(y.exp) > $signed(x.exp) || (y.exp == x.exp && y.man > x.man)) begin
         t = x;
         x = y;
         y = t;
      end
      d  = 13'($signed(x.exp) - $signed(y.exp));
      sx = {1'b0, x.man, 3'd0};
      sy = shr_sticky({1'b0, y.man, 3'd0}, d);
      if (x.sign == y.sign) return round_pack(x.sign, $signed(x.exp), sx + sy, rm);
      if (sx == sy) return {rm == RM_DOWN, 63'd0};
      return round_pack(x.sign, $signed(x.exp), sx - sy, rm);
   endfunction

   function automatic logic [63:0] mul(input logic [63:0] a, input logic [63:0] b,
                                       input logic [1:0] rm);
      fp_t                x;
      fp_t                y;
      logic               s;
      logic [105:0]       p;
      logic signed [12:0] e;
      x = unpack(a);
      y = unpack(b);
      s = x.sign ^ y.sign;
      if (x.nan || y.nan) return QNAN;
      if ((x.inf && y.zero) || (y.inf && x.zero)) return QNAN;
      if (x.inf || y.inf) return {s, 11'h7FF, 52'd0};
      if (x.zero || y.zero) return {s, 63'd0};
      p = 106'(x.man) * 106'(y.man);
      e = $signed(x.exp) + $signed(y.exp) - 13'sd1023;
      return round_pack(s, e, {p[105:50], |p[49:0]}, rm);
   endfunction

   logic [63:0] result;

   always_comb begin
      result = QNAN;
      case (op)
         FPU_ADD: result = add_sub(opa, opb, 1'b0, rmode);
         FPU_SUB: result = add_sub(opa, opb, 1'b1, rmode);
         FPU_MUL: result = mul(opa, opb, rmode);
         default: result = QNAN;
      endcase
   end

   // NOTE: registered state always uses non-blocking assignments.
   always_ff @(posedge clk_operation) begin
      if (rst) begin
         out   <= 64'd0;
         ready <= 1'b0;
      end else begin
         ready <= enable;
         if (enable) out <= result;
      end
   end

endmodule

// File: rtl/echo_cancel.sv
// Echo canceller: out = mic - sum(lag_i * coef_i), evaluated as eight
// sequential operations on one shared FPU.
module echo_cancel
   import echo_cancel_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter logic [1:0]  RMODE   = 2'b00
) (
   input  logic        clk_operation,
   input  logic        rst,
   input  logic        sample_valid,
   input  logic [63:0] signal,
   input  logic [63:0] mic,
   input  logic [63:0] para_0,
   input  logic [63:0] para_1,
   input  logic [63:0] para_2,
   input  logic [63:0] para_3,
   input  logic        para_load,
   output logic [63:0] out,
   output logic        out_valid,
   output logic        busy,
   output logic        overrun,
   output logic        error
);

   state_t      state;
   logic [2:0]  op_idx;
   logic [15:0] wait_cnt;
   logic [63:0] lag [4];
   logic [63:0] coef [4];
   logic [63:0] pend [4];
   logic [63:0] para_in [4];
   logic [63:0] coef_eff [4];
   logic        pend_flag;
   logic [63:0] mic_q;
   logic [63:0] acc;
   logic        fpu_en;
   logic [2:0]  fpu_op;
   logic [63:0] fpu_a;
   logic [63:0] fpu_b;
   logic [63:0] fpu_out;
   logic        fpu_ready;

   // A load in the same idle cycle as a sample wins over anything pending.
   always_comb begin
      para_in[0] = para_0;
      para_in[1] = para_1;
      para_in[2] = para_2;
      para_in[3] = para_3;
      for (int i = 0; i < 4; i++)
         coef_eff[i] = para_load ? para_in[i] : (pend_flag ? pend[i] : coef[i]);
   end

   echo_cancel_fpu u_fpu (
      .clk_operation (clk_operation),
      .rst           (rst),
      .enable        (fpu_en),
      .rmode         (RMODE),
      .op            (fpu_op),
      .opa           (fpu_a),
      .opb           (fpu_b),
      .out           (fpu_out),
      .ready         (fpu_ready)
   );

   always_ff @(posedge clk_operation) begin
      if (rst) begin
         state     <= ST_IDLE;
         op_idx    <= 3'd0;
         wait_cnt  <= 16'd0;
         pend_flag <= 1'b0;
         mic_q     <= 64'd0;
         acc       <= 64'd0;
         fpu_en    <= 1'b0;
         fpu_op    <= FPU_MUL;
         fpu_a     <= 64'd0;
         fpu_b     <= 64'd0;
         out       <= 64'd0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
         error     <= 1'b0;
         // NOTE: these small register arrays are reset explicitly; they are not RAMs.
         for (int i = 0; i < 4; i++) begin
            lag[i]  <= 64'd0;
            coef[i] <= COEF_RESET;
            pend[i] <= COEF_RESET;
         end
      end else begin
         out_valid <= 1'b0;
         overrun   <= sample_valid && (state != ST_IDLE);
         error     <= 1'b0;
         fpu_en    <= 1'b0;
         if (para_load) begin
            pend      <= para_in;
            pend_flag <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (pend_flag || para_load) begin
                  coef      <= coef_eff;
                  pend_flag <= 1'b0;
               end
               if (sample_valid) begin
                  lag[0] <= signal;
                  lag[1] <= lag[0];
                  lag[2] <= lag[1];
                  lag[3] <= lag[2];
                  mic_q  <= mic;
                  fpu_a  <= signal;
                  fpu_b  <= coef_eff[0];
                  fpu_op <= FPU_MUL;
                  fpu_en <= 1'b1;
                  op_idx <= 3'd0;
                  busy   <= 1'b1;
                  state  <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               wait_cnt <= 16'd0;
               state    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (fpu_ready) begin
                  if (op_idx == 3'd7) begin
                     out       <= fpu_out;
                     out_valid <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     op_idx <= op_idx + 3'd1;
                     fpu_en <= 1'b1;
                     state  <= ST_ISSUE;
                     // Even ops produce the running sum; odd ops produce a product to add.
                     if (!op_idx[0]) begin
                        acc <= fpu_out;
                        if (op_idx == 3'd6) begin
                           fpu_a  <= mic_q;
                           fpu_b  <= fpu_out;
                           fpu_op <= FPU_SUB;
                        end else begin
                           fpu_a  <= lag[2'(op_idx[2:1] + 2'd1)];
                           fpu_b  <= coef[2'(op_idx[2:1] + 2'd1)];
                           fpu_op <= FPU_MUL;
                        end
                     end else begin
                        fpu_a  <= acc;
                        fpu_b  <= fpu_out;
                        fpu_op <= FPU_ADD;
                     end
                  end
               end else if (wait_cnt == 16'(TIMEOUT - 2)) begin
                  error <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_echo_cancel.sv
// Directed bench for echo_cancel: a vector table of single samples plus
// hand-written overrun, coefficient-swap, timeout and abort sequences.
module tb_echo_cancel;

   localparam int unsigned TIMEOUT = 255;

   localparam logic [63:0] D0     = 64'h0000000000000000;
   localparam logic [63:0] D_HALF = 64'h3FE0000000000000;
   localparam logic [63:0] D1     = 64'h3FF0000000000000;
   localparam logic [63:0] D1P5   = 64'h3FF8000000000000;
   localparam logic [63:0] D2     = 64'h4000000000000000;
   localparam logic [63:0] D8     = 64'h4020000000000000;
   localparam logic [63:0] DM1    = 64'hBFF0000000000000;
   localparam logic [63:0] DM2    = 64'hC000000000000000;
   localparam logic [63:0] DM3    = 64'hC008000000000000;
   localparam logic [63:0] DM4    = 64'hC010000000000000;
   localparam logic [63:0] DM5    = 64'hC014000000000000;
   localparam logic [63:0] PINF   = 64'h7FF0000000000000;
   localparam logic [63:0] NINF   = 64'hFFF0000000000000;

   logic        clk_operation = 1'b0;
   logic        rst           = 1'b1;
   logic        sample_valid  = 1'b0;
   logic        para_load     = 1'b0;
   logic [63:0] signal        = 64'd0;
   logic [63:0] mic           = 64'd0;
   logic [63:0] para_0        = 64'd0;
   logic [63:0] para_1        = 64'd0;
   logic [63:0] para_2        = 64'd0;
   logic [63:0] para_3        = 64'd0;
   logic [63:0] out;
   logic        out_valid;
   logic        busy;
   logic        overrun;
   logic        error;

   int checks = 0;
   int errors = 0;

   echo_cancel #(.TIMEOUT(TIMEOUT), .RMODE(2'b00)) dut (
      .clk_operation (clk_operation),
      .rst           (rst),
      .sample_valid  (sample_valid),
      .signal        (signal),
      .mic           (mic),
      .para_0        (para_0),
      .para_1        (para_1),
      .para_2        (para_2),
      .para_3        (para_3),
      .para_load     (para_load),
      .out           (out),
      .out_valid     (out_valid),
      .busy          (busy),
      .overrun       (overrun),
      .error         (error)
   );

   always #5 clk_operation = ~clk_operation;

   typedef struct {
      logic        do_reset;
      logic        load;
      logic [63:0] coef;
      logic [63:0] sig;
      logic [63:0] mic;
      logic [63:0] exp_out;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_operation);
      #1;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      sample_valid = 1'b0;
      para_load    = 1'b0;
      tick();
      check("reset out", out, D0);
      check("reset out_valid", {63'd0, out_valid}, 64'd0);
      check("reset busy", {63'd0, busy}, 64'd0);
      check("reset overrun", {63'd0, overrun}, 64'd0);
      check("reset error", {63'd0, error}, 64'd0);
      rst = 1'b0;
   endtask

   // Present one sample (optionally with a coefficient load in the same cycle).
   task automatic start(input logic [63:0] s, input logic [63:0] m,
                        input logic load, input logic [63:0] c);
      signal       = s;
      mic          = m;
      sample_valid = 1'b1;
      para_load    = load;
      if (load) begin
         para_0 = c;
         para_1 = c;
         para_2 = c;
         para_3 = c;
      end
      tick();
      sample_valid = 1'b0;
      para_load    = 1'b0;
   endtask

   task automatic wait_out(input string name, input logic [63:0] exp_out);
      int n = 0;
      while (out_valid !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check({name, " out_valid"}, {63'd0, out_valid}, 64'd1);
      check({name, " out"}, out, exp_out);
      tick();
      check({name, " out_valid one cycle"}, {63'd0, out_valid}, 64'd0);
      check({name, " out hold"}, out, exp_out);
      check({name, " busy idle"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      int k;
      int seen;

      vecs[0] = '{do_reset: 1'b1, load: 1'b0, coef: D0,     sig: D1,   mic: D2, exp_out: D2};
      vecs[1] = '{do_reset: 1'b1, load: 1'b1, coef: D_HALF, sig: D1,   mic: D2, exp_out: D1P5};
      vecs[2] = '{do_reset: 1'b0, load: 1'b0, coef: D0,     sig: D1,   mic: D2, exp_out: D1};
      vecs[3] = '{do_reset: 1'b0, load: 1'b0, coef: D0,     sig: D1,   mic: D2, exp_out: D_HALF};
      vecs[4] = '{do_reset: 1'b0, load: 1'b0, coef: D0,     sig: D1,   mic: D2, exp_out: D0};
      vecs[5] = '{do_reset: 1'b0, load: 1'b1, coef: D1,     sig: D2,   mic: D0, exp_out: DM5};
      vecs[6] = '{do_reset: 1'b0, load: 1'b0, coef: D0,     sig: DM1,  mic: D1, exp_out: DM2};
      vecs[7] = '{do_reset: 1'b0, load: 1'b0, coef: D0,     sig: PINF, mic: D0, exp_out: NINF};

      tick();
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].do_reset) do_reset();
         start(vecs[i].sig, vecs[i].mic, vecs[i].load, vecs[i].coef);
         wait_out($sformatf("vec%0d", i), vecs[i].exp_out);
      end

      // Sample arriving mid-computation is dropped and flagged.
      do_reset();
      start(D1, D0, 1'b1, D1);
      check("ovr busy in issue", {63'd0, busy}, 64'd1);
      repeat (4) tick();
      signal       = D8;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      check("ovr pulse", {63'd0, overrun}, 64'd1);
      tick();
      check("ovr pulse width", {63'd0, overrun}, 64'd0);
      wait_out("ovr current", DM1);
      start(D2, D0, 1'b0, D0);
      wait_out("ovr next history", DM3);

      // Coefficient load mid-computation applies only to the next sample.
      start(D1, D0, 1'b0, D0);
      repeat (6) tick();
      para_0    = D_HALF;
      para_1    = D_HALF;
      para_2    = D_HALF;
      para_3    = D_HALF;
      para_load = 1'b1;
      tick();
      para_load = 1'b0;
      wait_out("swap old coef", DM4);
      start(D0, D0, 1'b0, D0);
      wait_out("swap new coef", DM2);

      // FPU never answers: error after TIMEOUT cycles, out untouched.
      force dut.fpu_ready = 1'b0;
      start(D1, D1, 1'b0, D0);
      k    = 0;
      seen = 0;
      while (error !== 1'b1 && k < int'(TIMEOUT) + 20) begin
         tick();
         k++;
         if (out_valid === 1'b1) seen++;
      end
      check("timeout latency", 64'(k), 64'(TIMEOUT));
      check("timeout no out_valid", 64'(seen), 64'd0);
      check("timeout out unchanged", out, DM2);
      tick();
      check("timeout error one cycle", {63'd0, error}, 64'd0);
      check("timeout busy low", {63'd0, busy}, 64'd0);
      release dut.fpu_ready;

      // Reset in the middle of a computation aborts it.
      start(D2, D1, 1'b0, D0);
      repeat (3) tick();
      check("abort busy before rst", {63'd0, busy}, 64'd1);
      do_reset();
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (out_valid === 1'b1) seen++;
      end
      check("abort no out_valid", 64'(seen), 64'd0);
      start(D1, D2, 1'b1, D1);
      wait_out("abort history cleared", D1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
